cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//   Sits between the processor clock source and the single-cycle RISC-V core.
//   Produces cpu_en, a one-cycle clock enable that gates every state update in the core.
//   Two modes, selected by a switch:
//   - step mode: one enable pulse per debounced press of a push-button.
//   - run mode: a free-running enable every RUN_DIV cycles.
//   Also counts retired steps for board display.
// PARAMETERS
//   DEBOUNCE_CYCLES  1000000    consecutive stable cycles to accept a button/switch change (>=1)
//   DB_W             20         debounce counter width; 2**DB_W > DEBOUNCE_CYCLES
//   RUN_DIV          100000000  run-mode period in clk cycles (>=1)
//   RUN_W            27         prescaler width; 2**RUN_W >= RUN_DIV
// PORTS
//   clk         in   1   processor clock; all logic on rising edge
//   resetC      in   1   synchronous, active-high reset
//   btn_step    in   1   raw step push-button, asynchronous, bouncy
//   sw_run      in   1   raw mode switch, asynchronous: 1 = run, 0 = step
//   halt        in   1   core halt request (level); blocks all enables while high
//   cpu_en      out  1   registered one-cycle enable to the core
//   step_count  out  16  number of cpu_en pulses issued, wraps
//   running     out  1   registered: debounced run mode AND NOT halt
// BEHAVIOUR
//   Reset state (resetC=1 at a clk edge): all of the following are 0:
//     - cpu_en, step_count, running
//     - synchronisers, debounced values, debounce counters, prescaler
//     - FSM state = S_IDLE
//   Reset mid-operation aborts any pending pulse; no pulse in the cycle after reset release.
//   Synchronisers: btn_step and sw_run each pass through a 2-flop synchroniser (2-cycle latency).
//   Debounce (per input, independent): each input has a debounced value db and a counter cnt.
//     - Synced value == db: cnt clears to 0.
//     - Otherwise cnt increments.
//     - When cnt reaches DEBOUNCE_CYCLES-1 while still differing, db flips and cnt clears.
//     - A single agreeing cycle restarts the count.
//   Step FSM, driven by db_btn:
//     - S_IDLE: db_btn=1 -> S_FIRE if step mode and halt=0; otherwise -> S_HOLD.
//     - S_FIRE: cpu_en=1 for exactly this cycle; -> S_HOLD unconditionally.
//     - S_HOLD: waits for db_btn=0 -> S_IDLE.
//     - Result: one pulse per press; holding the button never repeats.
//     - A press made in run mode or under halt is consumed without a pulse.
//     - A held button must be released after a switch to step mode before the next pulse.
//   Run mode (db_run=1):
//     - Prescaler counts 0..RUN_DIV-1 and wraps.
//     - cpu_en=1 in the cycle after prescaler==RUN_DIV-1.
//     - First pulse comes RUN_DIV cycles after db_run rises; the prescaler is cleared on db_run edges.
//     - RUN_DIV=1 gives cpu_en=1 every cycle.
//     - halt=1 freezes the prescaler and forces cpu_en=0; counting resumes from the held value.
//   Mode change (db_run toggles): prescaler clears. A pulse already committed (S_FIRE) still completes.
//   Priority: resetC > halt > mode source.
//   cpu_en can never be high on two consecutive cycles except in run mode with RUN_DIV=1.
//   step_count: +1 on every cycle with cpu_en=1; 16'hFFFF wraps to 16'h0000.
//   running: updates one cycle after db_run or halt changes.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, RUN_DIV=5)
//   1. Clean step press:
//      - Stimulus: sw_run=0; btn_step held 1 for 20 cycles, then 0.
//      - Required: exactly one cpu_en pulse, at cycle 2 (sync) + 4 (debounce) + 1 (FSM) after the edge; step_count=1.
//   2. Bounce:
//      - Stimulus: btn_step toggles 1,0,1,0,1 every 2 cycles, then held 1 for 10 cycles.
//      - Required: exactly one pulse, timed from the final stable 1.
//   3. Run mode:
//      - Stimulus: sw_run=1 stable; observe 30 cycles after db_run rises.
//      - Required: cpu_en high every 5th cycle, 6 pulses total; running=1.
//   4. Halt:
//      - Stimulus: in run mode, halt=1 for 12 cycles, then 0.
//      - Required: no pulses while halted; prescaler resumes; next pulse = 5 - (count at halt) cycles after release.
//   5. Wrap:
//      - Stimulus: force step_count to 16'hFFFE; issue 2 steps.
//      - Required: step_count reads FFFF, then 0000.
//   6. Reset and mode change:
//      - Stimulus: assert resetC in S_FIRE and in mid-debounce.
//      - Required: cpu_en=0 next cycle; all outputs 0.
//      - Stimulus: switch run->step with the button held.
//      - Required: no pulse until release and a new press.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the single-cycle core: one pulse per debounced button press (step) or one every RUN_DIV cycles (run).
// Pulse latency from a raw press is 2 sync + DEBOUNCE_CYCLES + 1 cycles; halt holds cpu_en low and freezes the run prescaler.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20,
    parameter int RUN_DIV         = 100000000,
    parameter int RUN_W           = 27
) (
    input  logic        clk,
    input  logic        resetC,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic        halt,
    output logic        cpu_en,
    output logic [15:0] step_count,
    output logic        running
);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_HOLD
    } state_t;

    state_t             state_q;
    logic               cpu_en_q;
    logic               btn_meta_q, btn_sync_q, run_meta_q, run_sync_q;
    logic               db_btn_q, db_btn_d, db_run_q, db_run_d;
    logic [DB_W-1:0]    btn_cnt_q, btn_cnt_d, run_cnt_q, run_cnt_d;
    logic [RUN_W-1:0]   presc_q, presc_d;
    logic [15:0]        step_count_q;
    logic               running_q;
    logic               btn_flip, run_flip, run_tick;

    always_comb begin
        btn_flip  = (btn_sync_q != db_btn_q) && (btn_cnt_q == DB_LAST);
        run_flip  = (run_sync_q != db_run_q) && (run_cnt_q == DB_LAST);
        btn_cnt_d = ((btn_sync_q == db_btn_q) || btn_flip) ? '0 : btn_cnt_q + DB_W'(1);
        run_cnt_d = ((run_sync_q == db_run_q) || run_flip) ? '0 : run_cnt_q + DB_W'(1);
        db_btn_d  = db_btn_q ^ btn_flip;
        db_run_d  = db_run_q ^ run_flip;

        // A mode edge restarts the period; a tick landing on the falling edge is dropped.
        run_tick = db_run_q && !halt && !run_flip && (presc_q == RUN_LAST);

        if (run_flip || !db_run_q) begin
            presc_d = '0;
        end else if (halt) begin
            presc_d = presc_q;
        end else if (presc_q == RUN_LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resetC) begin
            btn_meta_q   <= 1'b0;
            btn_sync_q   <= 1'b0;
            run_meta_q   <= 1'b0;
            run_sync_q   <= 1'b0;
            db_btn_q     <= 1'b0;
            db_run_q     <= 1'b0;
            btn_cnt_q    <= '0;
            run_cnt_q    <= '0;
            presc_q      <= '0;
            step_count_q <= '0;
            running_q    <= 1'b0;
        end else begin
            btn_meta_q   <= btn_step;
            btn_sync_q   <= btn_meta_q;
            run_meta_q   <= sw_run;
            run_sync_q   <= run_meta_q;
            db_btn_q     <= db_btn_d;
            db_run_q     <= db_run_d;
            btn_cnt_q    <= btn_cnt_d;
            run_cnt_q    <= run_cnt_d;
            presc_q      <= presc_d;
            step_count_q <= step_count_q + {15'd0, cpu_en_q};
            running_q    <= db_run_q & ~halt;
        end
    end

    // Step FSM: a press seen in run mode or under halt is parked in S_HOLD until release.
    always_ff @(posedge clk) begin
        if (resetC) begin
            state_q  <= S_IDLE;
            cpu_en_q <= 1'b0;
        end else begin
            cpu_en_q <= run_tick;
            case (state_q)
                S_IDLE: begin
                    if (db_btn_q) begin
                        if (!db_run_q && !halt) begin
                            state_q  <= S_FIRE;
                            cpu_en_q <= 1'b1;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_FIRE: state_q <= S_HOLD;
                S_HOLD: begin
                    if (!db_btn_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_en     = cpu_en_q;
    assign step_count = step_count_q;
    assign running    = running_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=5; inputs change on negedge, outputs sampled 2 time units after posedge.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        resetC = 1'b1;
    logic        btn_step = 1'b0;
    logic        sw_run = 1'b0;
    logic        halt = 1'b0;
    logic        cpu_en;
    logic [15:0] step_count;
    logic        running;

    int   cyc = 0;
    int   pulses = 0;
    int   last_pulse = -1;
    int   dbl = 0;
    logic prev_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   base, t0;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DB_W(3),
        .RUN_DIV(5),
        .RUN_W(3)
    ) dut (
        .clk(clk),
        .resetC(resetC),
        .btn_step(btn_step),
        .sw_run(sw_run),
        .halt(halt),
        .cpu_en(cpu_en),
        .step_count(step_count),
        .running(running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #2;
        if (cpu_en) begin
            pulses++;
            last_pulse = cyc;
            if (prev_en) dbl++;
        end
        prev_en = cpu_en;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic press();
        btn_step = 1'b1;
        tick(10);
        btn_step = 1'b0;
        tick(10);
    endtask

    initial begin
        tick(3);
        chk("rst_cpu_en", int'(cpu_en), 0);
        chk("rst_step_count", int'(step_count), 0);
        chk("rst_running", int'(running), 0);
        resetC = 1'b0;
        tick(2);

        // Clean press
        base = pulses; t0 = cyc;
        btn_step = 1'b1;
        tick(20);
        btn_step = 1'b0;
        tick(12);
        chk("clean_pulses", pulses - base, 1);
        chk("clean_time", last_pulse, t0 + 7);
        chk("clean_count", int'(step_count), 1);

        // Bouncy press
        base = pulses;
        btn_step = 1'b1; tick(2);
        btn_step = 1'b0; tick(2);
        btn_step = 1'b1; tick(2);
        btn_step = 1'b0; tick(2);
        btn_step = 1'b1; t0 = cyc;
        tick(10);
        btn_step = 1'b0;
        tick(12);
        chk("bounce_pulses", pulses - base, 1);
        chk("bounce_time", last_pulse, t0 + 7);
        chk("bounce_count", int'(step_count), 2);

        // Run mode: db_run rises at t0+6, pulses at t0+11,16,...,36
        t0 = cyc;
        sw_run = 1'b1;
        tick(6);
        base = pulses;
        tick(1);
        chk("run_running", int'(running), 1);
        tick(29);
        chk("run_pulses", pulses - base, 6);
        chk("run_last", last_pulse, t0 + 36);
        chk("run_count", int'(step_count), 7);

        // Halt with prescaler at 2
        tick(2);
        halt = 1'b1;
        base = pulses;
        tick(2);
        chk("halt_running", int'(running), 0);
        tick(10);
        chk("halt_pulses", pulses - base, 0);
        halt = 1'b0;
        tick(3);
        chk("halt_resume_time", last_pulse, t0 + 53);
        chk("halt_resume_pulses", pulses - base, 1);

        // Run -> step with the button held
        btn_step = 1'b1;
        tick(10);
        sw_run = 1'b0;
        tick(8);
        base = pulses;
        tick(20);
        chk("held_no_pulse", pulses - base, 0);
        chk("step_running", int'(running), 0);
        btn_step = 1'b0;
        tick(10);
        btn_step = 1'b1; t0 = cyc;
        tick(7);
        chk("repress_en", int'(cpu_en), 1);
        chk("repress_time", last_pulse, t0 + 7);
        tick(3);
        btn_step = 1'b0;
        tick(10);

        // Wrap
        force dut.step_count_q = 16'hFFFE;
        #1;
        release dut.step_count_q;
        press();
        chk("wrap_ffff", int'(step_count), 16'hFFFF);
        press();
        chk("wrap_0000", int'(step_count), 0);

        // Reset during S_FIRE
        btn_step = 1'b1;
        tick(7);
        chk("fire_en", int'(cpu_en), 1);
        resetC = 1'b1;
        btn_step = 1'b0;
        tick(1);
        chk("fire_rst_en", int'(cpu_en), 0);
        chk("fire_rst_count", int'(step_count), 0);
        chk("fire_rst_running", int'(running), 0);
        resetC = 1'b0;
        base = pulses;
        tick(10);
        chk("fire_rst_no_pulse", pulses - base, 0);

        // Reset mid-debounce with the button kept held: debounce restarts from scratch
        btn_step = 1'b1;
        tick(4);
        resetC = 1'b1;
        tick(1);
        resetC = 1'b0;
        t0 = cyc;
        base = pulses;
        tick(7);
        chk("db_rst_time", last_pulse, t0 + 7);
        chk("db_rst_pulses", pulses - base, 1);
        btn_step = 1'b0;
        tick(3);
        chk("db_rst_count", int'(step_count), 1);
        tick(10);

        chk("no_back_to_back", dbl, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
